// File: rtl/data_mem_responder_pkg.sv
// Shared types for the data memory responder: channel FSM states,
// operation codes and a small helper used for sizing counters.
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RESPOND = 2'd2
    } mem_chan_state_e;

    typedef logic mem_op_t;

    localparam mem_op_t OP_READ  = 1'b0;
    localparam mem_op_t OP_WRITE = 1'b1;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/data_mem_responder_if.sv
// Multi-channel read/write handshake between requesters and the data
// memory. master: requester side (drives valid/address/data).
// slave: memory side (drives ready and read data).
interface data_mem_responder_if #(
    parameter int CHANNELS  = 4,
    parameter int ADDR_BITS = 8,
    parameter int DATA_BITS = 8
);

    logic [CHANNELS-1:0]                read_valid;
    logic [CHANNELS-1:0][ADDR_BITS-1:0] read_address;
    logic [CHANNELS-1:0]                read_ready;
    logic [CHANNELS-1:0][DATA_BITS-1:0] read_data;
    logic [CHANNELS-1:0]                write_valid;
    logic [CHANNELS-1:0][ADDR_BITS-1:0] write_address;
    logic [CHANNELS-1:0][DATA_BITS-1:0] write_data;
    logic [CHANNELS-1:0]                write_ready;

    modport master (
        output read_valid,
        output read_address,
        output write_valid,
        output write_address,
        output write_data,
        input  read_ready,
        input  read_data,
        input  write_ready
    );

    modport slave (
        input  read_valid,
        input  read_address,
        input  write_valid,
        input  write_address,
        input  write_data,
        output read_ready,
        output read_data,
        output write_ready
    );

endinterface

// File: rtl/data_mem_responder_rr_arbiter.sv
// Round-robin arbiter: one grant per cycle among req bits, searching
// from the channel after the last one granted.
// Ports: clk, reset (sync, high), req[N], grant_valid, grant_idx.
module rr_arbiter #(
    parameter int N        = 4,
    parameter int IDX_BITS = (N > 1) ? $clog2(N) : 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [N-1:0]        req,
    output logic                grant_valid,
    output logic [IDX_BITS-1:0] grant_idx
);

    logic [IDX_BITS-1:0] last_q;

    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        for (int i = 1; i <= N; i++) begin
            if (!grant_valid &&
                req[IDX_BITS'((int'(last_q) + i) % N)]) begin
                grant_valid = 1'b1;
                grant_idx   = IDX_BITS'((int'(last_q) + i) % N);
            end
        end
    end

    // Pointer starts at N-1 so channel 0 is first in line after reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= IDX_BITS'(N - 1);
        end else if (grant_valid) begin
            last_q <= grant_idx;
        end
    end

endmodule

// File: rtl/data_mem_responder.sv
// Single-ported data memory shared by several requester channels with
// round-robin grant and fixed read/write response latency.
// Ports: clk, reset (sync, high), bus (slave side of the handshake).
module data_mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 8,
    parameter int CHANNELS      = 4,
    parameter int MEM_DEPTH     = 2 ** ADDR_BITS,
    parameter int READ_LATENCY  = 2,
    parameter int WRITE_LATENCY = 2
) (
    input  logic           clk,
    input  logic           reset,
    data_mem_responder_if.slave bus
);

    localparam int IDX_BITS =
        (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam int CH_BITS =
        (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam int CNT_BITS =
        $clog2(max_int(READ_LATENCY, WRITE_LATENCY) + 1);

    localparam logic [CNT_BITS-1:0] RD_LOAD =
        CNT_BITS'(READ_LATENCY - 1);
    localparam logic [CNT_BITS-1:0] WR_LOAD =
        CNT_BITS'(WRITE_LATENCY - 1);

    typedef struct packed {
        mem_op_t              op;
        logic [ADDR_BITS-1:0] addr;
        logic [DATA_BITS-1:0] data;
    } mem_req_t;

    logic [DATA_BITS-1:0] mem [MEM_DEPTH];

    mem_chan_state_e      state   [CHANNELS];
    mem_op_t              op_q    [CHANNELS];
    logic [CNT_BITS-1:0]  cnt     [CHANNELS];
    logic [DATA_BITS-1:0] word_q  [CHANNELS];
    logic [CHANNELS-1:0]  abort_q;

    logic [CHANNELS-1:0]                rd_rdy_q;
    logic [CHANNELS-1:0]                wr_rdy_q;
    logic [CHANNELS-1:0][DATA_BITS-1:0] rd_data_q;

    logic [CHANNELS-1:0] elig;
    logic [CHANNELS-1:0] chan_valid;
    logic                gnt_valid;
    logic [CH_BITS-1:0]  gnt_idx;
    mem_req_t            gnt_req;
    logic                in_range;
    logic [IDX_BITS-1:0] mem_idx;
    logic [DATA_BITS-1:0] rd_word;

    // chan_valid follows the valid of the op actually in flight, so a
    // read that is done does not keep the channel busy on write_valid.
    always_comb begin
        elig       = '0;
        chan_valid = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            elig[c] = (state[c] == IDLE) &&
                      (bus.read_valid[c] || bus.write_valid[c]);
            chan_valid[c] = (op_q[c] == OP_READ) ?
                            bus.read_valid[c] :
                            bus.write_valid[c];
        end
    end

    rr_arbiter #(
        .N        (CHANNELS),
        .IDX_BITS (CH_BITS)
    ) u_arb (
        .clk         (clk),
        .reset       (reset),
        .req         (elig),
        .grant_valid (gnt_valid),
        .grant_idx   (gnt_idx)
    );

    // Read wins when a channel raises both valids.
    always_comb begin
        if (bus.read_valid[gnt_idx]) begin
            gnt_req.op   = OP_READ;
            gnt_req.addr = bus.read_address[gnt_idx];
        end else begin
            gnt_req.op   = OP_WRITE;
            gnt_req.addr = bus.write_address[gnt_idx];
        end
        gnt_req.data = bus.write_data[gnt_idx];
    end

    assign in_range = {1'b0, gnt_req.addr} <
                      (ADDR_BITS + 1)'(MEM_DEPTH);
    assign mem_idx  = gnt_req.addr[IDX_BITS-1:0];
    assign rd_word  = in_range ? mem[mem_idx] : '0;

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!reset && gnt_valid && in_range &&
            gnt_req.op == OP_WRITE) begin
            mem[mem_idx] <= gnt_req.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int c = 0; c < CHANNELS; c++) begin
                state[c]  <= IDLE;
                op_q[c]   <= OP_READ;
                cnt[c]    <= '0;
                word_q[c] <= '0;
            end
            abort_q   <= '0;
            rd_rdy_q  <= '0;
            wr_rdy_q  <= '0;
            rd_data_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                unique case (state[c])
                    IDLE: begin
                        if (gnt_valid &&
                            gnt_idx == CH_BITS'(c)) begin
                            state[c]   <= BUSY;
                            op_q[c]    <= gnt_req.op;
                            abort_q[c] <= 1'b0;
                            if (gnt_req.op == OP_READ) begin
                                cnt[c]    <= RD_LOAD;
                                word_q[c] <= rd_word;
                            end else begin
                                cnt[c]    <= WR_LOAD;
                                word_q[c] <= '0;
                            end
                        end
                    end
                    BUSY: begin
                        // Remember an abort so the response is a
                        // single-cycle pulse even if valid returns.
                        if (!chan_valid[c]) begin
                            abort_q[c] <= 1'b1;
                        end
                        if (cnt[c] == '0) begin
                            state[c] <= RESPOND;
                            if (op_q[c] == OP_READ) begin
                                rd_rdy_q[c]  <= 1'b1;
                                rd_data_q[c] <= word_q[c];
                            end else begin
                                wr_rdy_q[c] <= 1'b1;
                            end
                        end else begin
                            cnt[c] <= cnt[c] - 1'b1;
                        end
                    end
                    RESPOND: begin
                        if (abort_q[c] || !chan_valid[c]) begin
                            state[c]     <= IDLE;
                            rd_rdy_q[c]  <= 1'b0;
                            wr_rdy_q[c]  <= 1'b0;
                            rd_data_q[c] <= '0;
                        end
                    end
                    default: begin
                        state[c] <= IDLE;
                    end
                endcase
            end
        end
    end

    assign bus.read_ready  = rd_rdy_q;
    assign bus.write_ready = wr_rdy_q;
    assign bus.read_data   = rd_data_q;

endmodule
